// File: rtl/jk_seq_driver_pkg.sv
// Shared definitions for the JK sequence driver: FSM encoding, target FIFO
// depth and the per-bit JK excitation rule.
package jk_seq_driver_pkg;

  localparam int TGT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } jk_state_e;

  // Returns {j, k} that moves one flip-flop from cur to tgt in a single clock.
  function automatic logic [1:0] jk_excite(input logic cur, input logic tgt,
                                           input logic use_toggle);
    logic [1:0] jk;
    jk = 2'b00;
    if (cur != tgt) begin
      if (use_toggle) jk = 2'b11;
      else            jk = tgt ? 2'b10 : 2'b01;
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// Four-entry target-pattern FIFO with a combinational head (rdata) and
// full/empty flags; push is ignored when full, pop is ignored when empty.
module jk_tgt_fifo
  import jk_seq_driver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(TGT_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TGT_FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [TGT_FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [TGT_FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TGT_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/jk_seq_driver.sv
// Drives an external bank of JK flip-flops to queued target patterns, checks
// the readback one cycle after each drive, and retries a bounded number of times.
module jk_seq_driver
  import jk_seq_driver_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             done,
  output logic             fail,
  output logic             err_sticky,
  input  logic             clr_err,
  output logic             busy
);

  localparam int RW = 3;

  jk_state_e        state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d, tgt_q, tgt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             err_q, err_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata, exc_tgt, exc_j, exc_k;
  logic             done_c, fail_c;

  // Handshake: a pattern transfers on a rising edge where in_valid && in_ready;
  // in_ready is !full of the FIFO, so a same-cycle pop never raises it.
  jk_tgt_fifo #(.WIDTH(WIDTH)) u_tgt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Excitation is always taken from live q; the target is the FIFO head when
  // starting a new pattern, otherwise the held target for a retry.
  assign exc_tgt = (state_q == ST_IDLE) ? fifo_rdata : tgt_q;

  always_comb begin
    exc_j = '0;
    exc_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {exc_j[i], exc_k[i]} = jk_excite(q[i], exc_tgt[i], USE_TOGGLE != 0);
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = '0;
    k_d      = '0;
    tgt_d    = tgt_q;
    retry_d  = retry_q;
    fifo_pop = 1'b0;
    done_c   = 1'b0;
    fail_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          tgt_d    = fifo_rdata;
          retry_d  = '0;
          j_d      = exc_j;
          k_d      = exc_k;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (q == tgt_q) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = ST_DRIVE;
        end else begin
          fail_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = fail_c ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      k_q     <= '0;
      tgt_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = !fifo_full;
  assign j          = j_q;
  assign k          = k_q;
  assign done       = done_c;
  assign fail       = fail_c;
  assign err_sticky = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: a set/reset instance and a toggle instance share the
// same stimulus, each driving its own behavioural JK bank.
module tb_jk_seq_driver;

  localparam int W           = 4;
  localparam int MAX_RETRY   = 2;
  localparam int DONE_PERIOD = 3;  // one DRIVE, CHECK, IDLE round per target

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] stuck = '0;

  logic         in_ready0, done0, fail0, err0, busy0;
  logic         in_ready1, done1, fail1, err1, busy1;
  logic [W-1:0] j0, k0, j1, k1, bank0, bank1;

  int           checks = 0;
  int           errors = 0;
  logic         exp_err = 1'b0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  jk_seq_driver #(.WIDTH(W), .MAX_RETRY(MAX_RETRY), .USE_TOGGLE(0)) u_dut_set (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .j(j0), .k(k0), .q(bank0), .done(done0),
    .fail(fail0), .err_sticky(err0), .clr_err(clr_err), .busy(busy0)
  );

  jk_seq_driver #(.WIDTH(W), .MAX_RETRY(MAX_RETRY), .USE_TOGGLE(1)) u_dut_tog (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .j(j1), .k(k1), .q(bank1), .done(done1),
    .fail(fail1), .err_sticky(err1), .clr_err(clr_err), .busy(busy1)
  );

  // JK characteristic equation: Q+ = J&~Q | ~K&Q; stuck bits read as 0.
  function automatic logic [W-1:0] jk_bank_next(input logic [W-1:0] cur,
                                                input logic [W-1:0] jv,
                                                input logic [W-1:0] kv);
    return (jv & ~cur) | (~kv & cur);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      bank0 <= jk_bank_next(bank0, j0, k0) & ~stuck;
      bank1 <= jk_bank_next(bank1, j1, k1) & ~stuck;
    end
  end

  function automatic logic [W-1:0] exp_j(input logic [W-1:0] cur,
                                         input logic [W-1:0] tgt, input bit tog);
    return tog ? (cur ^ tgt) : (tgt & ~cur);
  endfunction

  function automatic logic [W-1:0] exp_k(input logic [W-1:0] cur,
                                         input logic [W-1:0] tgt, input bit tog);
    return tog ? (cur ^ tgt) : (cur & ~tgt);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offers one target to an idle, empty driver and follows it to done or fail.
  task automatic run_target(input logic [W-1:0] tgt, input bit rand_clr);
    bit hit0, hit1, clr, last;
    check_eq("offer_rdy", in_ready0, 1);
    check_eq("offer_rdy_tog", in_ready1, 1);
    in_valid = 1'b1;
    in_data  = tgt;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("idle_busy", busy0, 0);
    for (int a = 0; a <= MAX_RETRY; a++) begin
      @(negedge clk);
      clr_err = 1'b0;
      check_eq("drive_busy", busy0, 1);
      check_eq("drive_j", j0, exp_j(bank0, tgt, 0));
      check_eq("drive_k", k0, exp_k(bank0, tgt, 0));
      check_eq("drive_j_tog", j1, exp_j(bank1, tgt, 1));
      check_eq("drive_k_tog", k1, exp_k(bank1, tgt, 1));
      check_eq("drive_err", err0, exp_err);
      @(negedge clk);
      hit0 = (bank0 == tgt);
      hit1 = (bank1 == tgt);
      last = (a == MAX_RETRY);
      check_eq("check_done", done0, hit0);
      check_eq("check_fail", fail0, !hit0 && last);
      check_eq("check_done_tog", done1, hit1);
      check_eq("check_fail_tog", fail1, !hit1 && last);
      check_eq("check_jk_zero", {j0, k0}, 0);
      clr = rand_clr && ($urandom_range(0, 1) == 1);
      clr_err = clr;
      if (!hit0 && last) exp_err = 1'b1;
      else if (clr)      exp_err = 1'b0;
      if (hit0 || last) break;
    end
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("after_busy", busy0, 0);
    check_eq("after_jk_zero", {j0, k0, j1, k1}, 0);
    check_eq("after_err", err0, exp_err);
    check_eq("after_err_tog", err1, exp_err);
  endtask

  // A failing 0001 (bit0 stuck) keeps the engine busy while five patterns are offered.
  task automatic fifo_full_test();
    logic [W-1:0] p [5];
    logic [W-1:0] front;
    int drives = 0;
    int fails = 0;
    int dones = 0;
    int last_done = -1;
    for (int i = 0; i < 5; i++) p[i] = W'($urandom) & ~W'(1);
    stuck = W'(1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = W'(1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c <= 5 && (j0 | k0) != '0) drives++;
      if (fail0) fails++;
      if (c == 5) begin
        check_eq("full_fail", fail0, 1);
        check_eq("full_fail_tog", fail1, 1);
        exp_err = 1'b1;
        stuck = '0;
      end
      if (c >= 4 && c <= 6) check_eq("full_rdy_low", in_ready0, 0);
      if (c == 7) check_eq("full_rdy_back", in_ready0, 1);
      check_eq("full_excl", done0 && fail0, 0);
      if (done0) begin
        check_eq("full_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          front = exp_q.pop_front();
          check_eq("full_order", bank0, front);
          check_eq("full_order_tog", bank1, front);
        end
        if (last_done >= 0) check_eq("full_gap", c - last_done, DONE_PERIOD);
        last_done = c;
        dones++;
      end
      if (c < 5) begin
        check_eq("full_rdy", in_ready0, c < 4);
        if (c < 4) exp_q.push_back(p[c]);
        in_valid = 1'b1;
        in_data  = p[c];
      end else begin
        in_valid = 1'b0;
      end
    end
    check_eq("full_drives", drives, 3);
    check_eq("full_fail_cnt", fails, 1);
    check_eq("full_done_cnt", dones, 4);
    check_eq("full_q_left", exp_q.size(), 0);
    check_eq("full_err", err0, exp_err);
    check_eq("full_busy_end", busy0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_ready", in_ready0, 1);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_jk", {j0, k0, j1, k1}, 0);
    check_eq("rst_done_fail", {done0, fail0, done1, fail1}, 0);
    check_eq("rst_err", {err0, err1}, 0);
    rst_n = 1'b1;

    run_target(4'b1010, 0);
    check_eq("basic_q", bank0, 4'b1010);
    run_target(4'b0110, 0);
    check_eq("mixed_q", bank0, 4'b0110);
    check_eq("mixed_q_tog", bank1, 4'b0110);
    run_target(4'b0110, 0);
    check_eq("same_q", bank0, 4'b0110);

    fifo_full_test();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_err = 1'b0;
    check_eq("clr_err", err0, 0);
    check_eq("clr_err_tog", err1, 0);

    repeat (40) begin
      stuck = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      @(negedge clk);
      run_target(W'($urandom), 1);
    end
    stuck = '0;
    @(negedge clk);

    in_valid = 1'b1;
    in_data  = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rstmid_busy", busy0, 1);
    check_eq("rstmid_j", j0, exp_j(bank0, 4'b1111, 0));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_jk", {j0, k0, j1, k1}, 0);
    check_eq("rstmid_busy_low", busy0, 0);
    check_eq("rstmid_ready", in_ready0, 1);
    check_eq("rstmid_err", err0, 0);
    exp_err = 1'b0;
    @(negedge clk);
    check_eq("rstmid_no_done", {done0, fail0, done1, fail1}, 0);
    check_eq("rstmid_bank", bank0, 0);
    rst_n = 1'b1;
    run_target(4'b0011, 0);
    check_eq("post_rst_q", bank0, 4'b0011);
    check_eq("post_rst_q_tog", bank1, 4'b0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
